pdm_mic_ctrl: RTL
=================

PDM_MIC_CTRL -- requirements
Module: pdm_mic_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per pdm_clk_o half-period; legal range 2..255.
REQ-002 SHALL have parameter WARMUP, default 4: number of stereo frames discarded after each enable; legal range 0..255.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output frame FIFO depth; must be a power of 2, at least 2.
REQ-004 Port: clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: enable  in  1  level; 1 = run the microphone, 0 = stop.
REQ-007 Port: pdm_clk_o  out  1  clock driven to the stereo PDM microphone pair.
REQ-008 Port: pdm_data_i  in  1  shared PDM data line; left drives during the low phase, right during the high phase.
REQ-009 Port: bit_l_o / bit_l_stb_o  out  1/1  left PDM bit and its one-cycle strobe, to the left decimator.
REQ-010 Port: bit_r_o / bit_r_stb_o  out  1/1  right PDM bit and its one-cycle strobe, to the right decimator.
REQ-011 Port: pcm_l_i / pcm_l_valid_i  in  16 signed/1  left decimator output sample and its one-cycle valid.
REQ-012 Port: pcm_r_i / pcm_r_valid_i  in  16 signed/1  right decimator output sample and its one-cycle valid.
REQ-013 Port: frame_o  out  32  stereo frame {left[31:16], right[15:0]}.
REQ-014 Port: frame_valid_o / frame_ready_i  out/in  1/1  valid/ready handshake for frame_o.
REQ-015 Port: overflow_o  out  1  sticky error flag (FIFO full or channel desync).
REQ-016 Port: state_o  out  2  current state; IDLE=0, WARMUP=1, RUN=2.

Function
REQ-017 SHALL implement a state machine with these transitions:
  - IDLE -> WARMUP when enable=1;
  - WARMUP -> RUN once WARMUP frames have been assembled; WARMUP=0 goes straight to RUN;
  - any state -> IDLE on the cycle enable=0 is sampled.
REQ-018 In IDLE: divider counter = 0, pdm_clk_o = 0, no strobes, pending flags cleared.
REQ-019 Divider SHALL count 0..CLK_DIV-1 outside IDLE; at terminal count pdm_clk_o toggles on the next edge.
REQ-020 At a terminal count with pdm_clk_o=0: pdm_data_i is captured into bit_l_o and bit_l_stb_o=1 for the next cycle, concurrent with pdm_clk_o rising.
REQ-021 At a terminal count with pdm_clk_o=1: same capture into bit_r_o with bit_r_stb_o.
REQ-022 Strobes are never both high in one cycle; each channel's strobe period is exactly 2*CLK_DIV cycles.
REQ-023 A pcm_x_valid_i pulse latches pcm_x_i and sets pending_x.
REQ-024 When both pending flags are set (including same-cycle arrival), a frame is complete:
  - push it to the FIFO (RUN) or count it as discarded (WARMUP);
  - clear both flags on the same edge.
REQ-025 A valid on an already-pending channel overwrites the held sample and sets overflow_o (desync).
REQ-026 Push when FIFO is full: frame dropped and overflow_o set, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-027 frame_valid_o = FIFO not empty and frame_o = FIFO head; pop when frame_valid_o && frame_ready_i.
REQ-028 Latency from a frame push into an empty FIFO to frame_valid_o=1 is 1 cycle.
REQ-029 FIFO contents are retained and remain drainable in IDLE.
REQ-030 overflow_o clears only on reset or on the IDLE -> WARMUP transition.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH and use an extra MSB to distinguish full from empty.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, pdm_clk_o=0, all strobes=0, bit_l_o=bit_r_o=0, frame_valid_o=0, frame_o=0, overflow_o=0, FIFO empty, pending flags and warmup counter cleared.
REQ-033 Reset deassertion mid-operation SHALL resume in IDLE; no partial frame survives.

Structure
REQ-034 Shared package SHALL hold the state encoding constants (IDLE/WARMUP/RUN), the frame width (32) and the PCM width (16).
REQ-035 SHALL contain one sub-module, frame_fifo: synchronous FIFO parameterised on width and depth, exposing full and empty.
REQ-036 Decimators SHALL remain external; this block only sequences them.

Verification
REQ-037 enable=1, CLK_DIV=4, pdm_data_i toggling -> pdm_clk_o period is 8 cycles; bit_l_stb_o and bit_r_stb_o alternate every 4 cycles; captured bits match the line.
REQ-038 WARMUP=4; feed 6 paired valids with L=0x1000+n, R=-n -> exactly 2 frames out: 0x1004FFFC then 0x1005FFFB.
REQ-039 frame_ready_i=0, feed 5 frames (depth 4) -> 4 held, overflow_o=1; release ready -> 4 frames in order.
REQ-040 pcm_l_valid_i twice before any pcm_r_valid_i -> overflow_o=1; frame carries the second left value.
REQ-041 Drop enable mid-run with 2 frames queued -> state_o=0 next cycle, pdm_clk_o=0, both frames still drain; re-enable -> overflow_o cleared.
REQ-042 Assert rst_n=0 while frames are queued and pdm_clk_o=1 -> all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pdm_mic_ctrl_pkg.sv
// Shared definitions for the stereo PDM microphone controller: state
// encoding, sample/frame widths and the frame packing helper.
package pdm_mic_ctrl_pkg;

  localparam int FRAME_W = 32;
  localparam int PCM_W   = 16;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Stereo frame layout: left sample in the upper half, right in the lower.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [PCM_W-1:0] left,
    input logic [PCM_W-1:0] right
  );
    return {left, right};
  endfunction

endpackage

// File: rtl/pdm_mic_ctrl_frame_fifo.sv
// Synchronous frame FIFO. Pointers carry one extra MSB so that full and
// empty are distinguishable without a separate count. A push while full is
// accepted only when a pop happens on the same edge; otherwise it is ignored
// and the owner is expected to flag the loss. The head reads as zero when
// the FIFO is empty.
module frame_fifo
  import pdm_mic_ctrl_pkg::*;
#(
  parameter int WIDTH = FRAME_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// Stereo PDM microphone controller. Generates the microphone clock, splits
// the shared data line into left/right bit streams for external decimators,
// pairs the decimated samples into stereo frames, discards the first WARMUP
// frames after each enable and queues the rest for a downstream consumer.
//
// Output handshake: frame_o is valid whenever frame_valid_o is high and is
// held stable until accepted; a frame is consumed on every rising clk edge
// where frame_valid_o && frame_ready_i. frame_valid_o never depends
// combinationally on frame_ready_i.
module pdm_mic_ctrl
  import pdm_mic_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int WARMUP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    pdm_clk_o,
  input  logic                    pdm_data_i,
  output logic                    bit_l_o,
  output logic                    bit_l_stb_o,
  output logic                    bit_r_o,
  output logic                    bit_r_stb_o,
  input  logic signed [PCM_W-1:0] pcm_l_i,
  input  logic                    pcm_l_valid_i,
  input  logic signed [PCM_W-1:0] pcm_r_i,
  input  logic                    pcm_r_valid_i,
  output logic [FRAME_W-1:0]      frame_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    overflow_o,
  output logic [1:0]              state_o
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_e                  r_state;
  logic [7:0]              r_warm_cnt;
  logic [7:0]              r_div;
  logic                    r_pdm_clk;
  logic                    r_bit_l;
  logic                    r_stb_l;
  logic                    r_bit_r;
  logic                    r_stb_r;
  logic                    r_pend_l;
  logic                    r_pend_r;
  logic signed [PCM_W-1:0] r_pcm_l;
  logic signed [PCM_W-1:0] r_pcm_r;
  logic                    r_ovf;

  logic                    w_active;
  logic                    w_tc;
  logic                    w_lv;
  logic                    w_rv;
  logic [PCM_W-1:0]        w_l_held;
  logic [PCM_W-1:0]        w_r_held;
  logic                    w_frame_done;
  logic                    w_desync;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [FRAME_W-1:0]      w_head;

  // The block only does work in WARMUP/RUN while enable is still high; the
  // cycle enable is sampled low behaves as IDLE for every datapath register.
  assign w_active     = (r_state != ST_IDLE) && enable;
  assign w_tc         = (r_div == DIV_LAST);
  assign w_lv         = w_active && pcm_l_valid_i;
  assign w_rv         = w_active && pcm_r_valid_i;
  assign w_l_held     = w_lv ? pcm_l_i : r_pcm_l;
  assign w_r_held     = w_rv ? pcm_r_i : r_pcm_r;
  assign w_frame_done = w_active && (r_pend_l || w_lv) && (r_pend_r || w_rv);
  assign w_desync     = (w_lv && r_pend_l) || (w_rv && r_pend_r);
  assign w_push       = w_frame_done && (r_state == ST_RUN);
  assign w_pop        = frame_valid_o && frame_ready_i;
  assign w_drop       = w_push && w_full && !w_pop;

  // Controller state and warm-up frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_warm_cnt <= '0;
    end else if (!enable) begin
      r_state    <= ST_IDLE;
      r_warm_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_warm_cnt <= '0;
          r_state    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          if (w_frame_done) begin
            if (r_warm_cnt == WARM_LAST) begin
              r_state <= ST_RUN;
            end else begin
              r_warm_cnt <= r_warm_cnt + 8'd1;
            end
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Microphone clock divider and left/right bit capture. Left data is taken
  // at the end of the low phase (as the clock rises), right data at the end
  // of the high phase (as the clock falls).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
      r_bit_l   <= 1'b0;
      r_stb_l   <= 1'b0;
      r_bit_r   <= 1'b0;
      r_stb_r   <= 1'b0;
    end else if (!w_active) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
      r_stb_l   <= 1'b0;
      r_stb_r   <= 1'b0;
    end else begin
      r_stb_l <= 1'b0;
      r_stb_r <= 1'b0;
      if (w_tc) begin
        r_div     <= '0;
        r_pdm_clk <= ~r_pdm_clk;
        if (!r_pdm_clk) begin
          r_bit_l <= pdm_data_i;
          r_stb_l <= 1'b1;
        end else begin
          r_bit_r <= pdm_data_i;
          r_stb_r <= 1'b1;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  // Sample holding and pairing: each channel waits until the other arrives,
  // and both pending flags drop on the edge the frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_l <= 1'b0;
      r_pend_r <= 1'b0;
      r_pcm_l  <= '0;
      r_pcm_r  <= '0;
    end else if (!w_active) begin
      r_pend_l <= 1'b0;
      r_pend_r <= 1'b0;
    end else begin
      if (w_lv) r_pcm_l <= pcm_l_i;
      if (w_rv) r_pcm_r <= pcm_r_i;
      if (w_frame_done) begin
        r_pend_l <= 1'b0;
        r_pend_r <= 1'b0;
      end else begin
        if (w_lv) r_pend_l <= 1'b1;
        if (w_rv) r_pend_r <= 1'b1;
      end
    end
  end

  // Sticky error flag: set by a desynchronised channel or a dropped frame,
  // cleared only when a new enable session starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_IDLE) && enable) begin
      r_ovf <= 1'b0;
    end else if (w_desync || w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (pack_frame(w_l_held, w_r_held)),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pdm_clk_o     = r_pdm_clk;
  assign bit_l_o       = r_bit_l;
  assign bit_l_stb_o   = r_stb_l;
  assign bit_r_o       = r_bit_r;
  assign bit_r_stb_o   = r_stb_r;
  assign frame_o       = w_head;
  assign frame_valid_o = !w_empty;
  assign overflow_o    = r_ovf;
  assign state_o       = r_state;

endmodule
